// File: rtl/load_store_pkg.sv
// Shared definitions for the store unload controller.
//   state_t   : controller states (IDLE, DRAIN, DONE)
//   N_DEF     : default store capacity in units
//   CBITS_DEF : default width of the unit counter
package load_store_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int N_DEF     = 10000;
    localparam int CBITS_DEF = 14;

endpackage

// File: rtl/unload_store_sat_down_counter.sv
// Saturating down-counter that holds the number of units left in the store.
// Ports:
//   clk      : clock
//   rst      : asynchronous active-low reset, clears the count
//   load     : load load_val (has priority over dec)
//   dec      : decrement by one; the count never goes below zero
//   load_val : value taken on load
//   count    : current count
//   zero     : count is zero
module sat_down_counter
    import load_store_pkg::*;
#(
    parameter int CBITS = CBITS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CBITS-1:0] load_val,
    output logic [CBITS-1:0] count,
    output logic             zero
);

    assign zero = (count == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/unload_store.sv
// Store unload controller: once the loading side reports the store full,
// offers the stored units downstream one at a time until the store is empty,
// then pulses empty for one cycle and returns to idle.
//
//   state | meaning
//   IDLE  | waiting for full; vol holds its last value (0 after a drain)
//   DRAIN | out_valid offered; each accepted unit decrements vol
//   DONE  | store just emptied; empty pulses for this one cycle
//
// Ports:
//   clk       : clock
//   rst       : asynchronous active-low reset
//   full      : store-full level from the loading side
//   out_ready : downstream accepts one unit this cycle
//   out_valid : one unit is offered downstream
//   vol       : units remaining in the store
//   busy      : drain in progress
//   empty     : single-cycle pulse when the store reaches zero
//
// Optional build macro UNLOAD_STORE_ASSERT_EN compiles in embedded
// concurrent properties; behaviour is the same either way.
module unload_store
    import load_store_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CBITS = CBITS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             full,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CBITS-1:0] vol,
    output logic             busy,
    output logic             empty
);

    localparam logic [CBITS-1:0] N_VAL = CBITS'(N);

    state_t state;
    logic   transfer;
    logic   last;
    logic   load;
    logic   dec;
    logic   zero;

    assign transfer = (state == DRAIN) && out_valid && out_ready;
    // The final unit is the one accepted while exactly one remains.
    assign last     = transfer && (vol == CBITS'(1));
    assign load     = (state == IDLE) && full;
    assign dec      = transfer && !zero;

    sat_down_counter #(
        .CBITS (CBITS)
    ) u_vol (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .dec      (dec),
        .load_val (N_VAL),
        .count    (vol),
        .zero     (zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            empty     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    empty <= 1'b0;
                    if (full) begin
                        state     <= DRAIN;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                DRAIN: begin
                    // full is deliberately ignored here; no reload mid-drain.
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        empty     <= 1'b1;
                    end
                end
                DONE: begin
                    // Always pass through IDLE so a held full cannot restart
                    // the drain straight out of DONE.
                    state <= IDLE;
                    empty <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    empty     <= 1'b0;
                end
            endcase
        end
    end

`ifdef UNLOAD_STORE_ASSERT_EN
    a_busy_until_empty: assert property (@(posedge clk) disable iff (!rst)
        busy |-> (busy s_until empty));

    a_stall_holds_vol: assert property (@(posedge clk) disable iff (!rst)
        (out_valid && !out_ready) |=> $stable(vol));

    a_vol_bounded: assert property (@(posedge clk) disable iff (!rst)
        vol <= N_VAL);

    a_empty_at_zero: assert property (@(posedge clk) disable iff (!rst)
        empty |-> (vol == '0));
`endif

endmodule

// File: tb/tb_unload_store.sv
module tb_unload_store;

    localparam int NS = 5;
    localparam int NB = 10000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        full5 = 1'b0, ready5 = 1'b0;
    logic        fullb = 1'b0, readyb = 1'b0;
    logic        valid5, busy5, empty5;
    logic        validb, busyb, emptyb;
    logic [13:0] vol5, volb;

    int errors = 0;
    int checks = 0;
    int vmax_b = 0;

    // Reference model: index 0 is the N=5 instance, 1 the default instance.
    int m_n[2] = '{NS, NB};
    int m_vol[2];
    bit m_valid[2];
    bit m_empty[2];

    always #5 clk = ~clk;

    unload_store #(.N(NS), .CBITS(14)) dut5 (
        .clk(clk), .rst(rst), .full(full5), .out_ready(ready5),
        .out_valid(valid5), .vol(vol5), .busy(busy5), .empty(empty5)
    );

    unload_store dutb (
        .clk(clk), .rst(rst), .full(fullb), .out_ready(readyb),
        .out_valid(validb), .vol(volb), .busy(busyb), .empty(emptyb)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_vol[i] = 0; m_valid[i] = 0; m_empty[i] = 0;
        end
    endtask

    // Behaviour of one clock edge, stated in terms of the store contents:
    // while units are offered each accepted one leaves the store; the edge
    // after the store runs dry is the empty pulse; only afterwards can a
    // full store start a new unload.
    task automatic model_edge();
        bit f, r;
        if (!rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            f = (i == 0) ? full5 : fullb;
            r = (i == 0) ? ready5 : readyb;
            if (m_valid[i]) begin
                if (r) begin
                    m_vol[i] = m_vol[i] - 1;
                    if (m_vol[i] == 0) begin
                        m_valid[i] = 0;
                        m_empty[i] = 1;
                    end
                end
            end else if (m_empty[i]) begin
                m_empty[i] = 0;
            end else if (f) begin
                m_vol[i]   = m_n[i];
                m_valid[i] = 1;
            end
        end
    endtask

    task automatic compare_all();
        check("vol5",   int'(vol5),   m_vol[0]);
        check("valid5", int'(valid5), int'(m_valid[0]));
        check("busy5",  int'(busy5),  int'(m_valid[0]));
        check("empty5", int'(empty5), int'(m_empty[0]));
        check("volb",   int'(volb),   m_vol[1]);
        check("validb", int'(validb), int'(m_valid[1]));
        check("busyb",  int'(busyb),  int'(m_valid[1]));
        check("emptyb", int'(emptyb), int'(m_empty[1]));
        if (int'(volb) > vmax_b) vmax_b = int'(volb);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int n_empty;
        model_reset();

        // Reset held low: everything at zero.
        repeat (2) step();
        rst = 1'b1;
        step();

        // Single-cycle full, downstream always ready.
        full5 = 1'b1; step(); full5 = 1'b0; ready5 = 1'b1;
        check("latency_vol5", int'(vol5), NS);
        n_empty = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (empty5) n_empty++;
        end
        check("one_empty_pulse", n_empty, 1);

        // Alternating ready: stalls must hold vol and keep out_valid high.
        full5 = 1'b1; step(); full5 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            ready5 = ((k % 2) == 0);
            step();
        end

        // full held through the drain and beyond.
        full5 = 1'b1; ready5 = 1'b1;
        repeat (24) step();
        full5 = 1'b0;
        repeat (4) step();

        // Random traffic on the small instance.
        for (int k = 0; k < 400; k++) begin
            full5  = ($urandom_range(0, 3) == 0);
            ready5 = $urandom_range(0, 1);
            step();
        end
        full5 = 1'b0; ready5 = 1'b1;
        repeat (12) step();

        // Full-size drain with ready always high.
        fullb = 1'b1; step(); fullb = 1'b0; readyb = 1'b1;
        check("latency_volb", int'(volb), NB);
        cnt = 0;
        while (!emptyb && cnt < 12000) begin
            step();
            cnt++;
        end
        check("drain_length", cnt, NB);
        step();
        check("vol_max_ok", int'(vmax_b <= NB), 1);

        // Second drain, reset asynchronously at vol 37.
        fullb = 1'b1; step(); fullb = 1'b0;
        cnt = 0;
        while (m_vol[1] != 37 && cnt < 12000) begin
            step();
            cnt++;
        end
        check("reached_37", int'(volb), 37);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("async_volb",   int'(volb),   0);
        check("async_validb", int'(validb), 0);
        check("async_busyb",  int'(busyb),  0);
        check("async_emptyb", int'(emptyb), 0);
        check("async_vol5",   int'(vol5),   0);
        step();
        rst = 1'b1;
        n_empty = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (emptyb) n_empty++;
        end
        check("no_empty_after_reset", n_empty, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
